// File: rtl/ram_access_arbiter.sv
`timescale 1ns/1ps
// Shares the single ROMulator RAM port between the CPU bus front end and the SPI diagnostics
// engine; sequences each access and returns a one-cycle ack to the requester that won.
module ram_access_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int WRITE_PULSE  = 1,
    parameter int STARVE_LIMIT = 255
) (
    input  logic                  fpga_clk,
    input  logic                  fpga_reset,
    input  logic                  halted,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  diag_req,
    input  logic                  diag_we,
    input  logic [ADDR_WIDTH-1:0] diag_address,
    input  logic [DATA_WIDTH-1:0] diag_wdata,
    output logic [DATA_WIDTH-1:0] diag_rdata,
    output logic                  diag_ack,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    output logic                  ram_cs,
    output logic [1:0]            owner,
    output logic                  diag_starved
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_CAPTURE,
        S_GAP
    } state_t;

    localparam logic [3:0] PULSE_LAST = 4'(WRITE_PULSE - 1);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [1:0] OWN_NONE   = 2'b00;
    localparam logic [1:0] OWN_CPU    = 2'b01;
    localparam logic [1:0] OWN_DIAG   = 2'b10;

    state_t     state;
    logic       sel_diag;
    logic       sel_we;
    logic [3:0] pulse_cnt;
    logic [7:0] starve_cnt;
    logic       grant_cpu;
    logic       grant_diag;
    logic       diag_granted;
    logic       serving_diag;

    // Halted CPU hands priority to diagnostics; otherwise the CPU wins ties.
    always_comb begin
        grant_cpu    = cpu_req  && (!halted || !diag_req);
        grant_diag   = diag_req && ( halted || !cpu_req);
        diag_granted = (state == S_IDLE) && grant_diag;
        serving_diag = sel_diag && (state inside {S_SETUP, S_STROBE, S_HOLD, S_CAPTURE});
    end

    assign diag_starved = (starve_cnt == STARVE_MAX);

    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            state        <= S_IDLE;
            sel_diag     <= 1'b0;
            sel_we       <= 1'b0;
            pulse_cnt    <= 4'd0;
            starve_cnt   <= 8'd0;
            cpu_rdata    <= '0;
            cpu_ack      <= 1'b0;
            diag_rdata   <= '0;
            diag_ack     <= 1'b0;
            ram_address  <= '0;
            ram_data_out <= '0;
            ram_we       <= 1'b0;
            ram_cs       <= 1'b0;
            owner        <= OWN_NONE;
        end else begin
            cpu_ack  <= 1'b0;
            diag_ack <= 1'b0;

            case (state)
                S_IDLE: begin
                    owner  <= OWN_NONE;
                    ram_cs <= 1'b0;
                    ram_we <= 1'b0;
                    if (grant_diag) begin
                        sel_diag     <= 1'b1;
                        sel_we       <= diag_we;
                        ram_address  <= diag_address;
                        ram_data_out <= diag_wdata;
                        owner        <= OWN_DIAG;
                        ram_cs       <= 1'b1;
                        state        <= S_SETUP;
                    end else if (grant_cpu) begin
                        sel_diag     <= 1'b0;
                        sel_we       <= cpu_we;
                        ram_address  <= cpu_address;
                        ram_data_out <= cpu_wdata;
                        owner        <= OWN_CPU;
                        ram_cs       <= 1'b1;
                        state        <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (sel_we) begin
                        ram_we    <= 1'b1;
                        pulse_cnt <= PULSE_LAST;
                        state     <= S_STROBE;
                    end else begin
                        state <= S_CAPTURE;
                    end
                end

                S_STROBE: begin
                    if (pulse_cnt == 4'd0) begin
                        ram_we <= 1'b0;
                        state  <= S_HOLD;
                    end else begin
                        pulse_cnt <= pulse_cnt - 4'd1;
                    end
                end

                S_HOLD: begin
                    ram_cs <= 1'b0;
                    owner  <= OWN_NONE;
                    if (sel_diag) diag_ack <= 1'b1;
                    else          cpu_ack  <= 1'b1;
                    state  <= S_GAP;
                end

                // Read data arrives one cycle after address/cs; only the owner's rdata moves.
                S_CAPTURE: begin
                    ram_cs <= 1'b0;
                    owner  <= OWN_NONE;
                    if (sel_diag) begin
                        diag_rdata <= ram_data_in;
                        diag_ack   <= 1'b1;
                    end else begin
                        cpu_rdata <= ram_data_in;
                        cpu_ack   <= 1'b1;
                    end
                    state <= S_GAP;
                end

                S_GAP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (!diag_req || diag_granted || serving_diag) begin
                starve_cnt <= 8'd0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
`timescale 1ns/1ps
// Randomized bench for ram_access_arbiter: a behavioural RAM, a transaction-level reference
// memory and arbitration rules predict which requester is acked, when, and with what data.
module tb_ram_access_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int WP = 3;
    localparam int SL = 10;

    logic          fpga_clk     = 1'b0;
    logic          fpga_reset   = 1'b1;
    logic          halted       = 1'b0;
    logic          cpu_req      = 1'b0;
    logic          cpu_we       = 1'b0;
    logic [AW-1:0] cpu_address  = '0;
    logic [DW-1:0] cpu_wdata    = '0;
    logic          diag_req     = 1'b0;
    logic          diag_we      = 1'b0;
    logic [AW-1:0] diag_address = '0;
    logic [DW-1:0] diag_wdata   = '0;
    logic [DW-1:0] ram_data_in  = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic [DW-1:0] diag_rdata;
    logic          diag_ack;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_out;
    logic          ram_we;
    logic          ram_cs;
    logic [1:0]    owner;
    logic          diag_starved;

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ram_access_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .WRITE_PULSE (WP),
        .STARVE_LIMIT(SL)
    ) dut (
        .fpga_clk    (fpga_clk),
        .fpga_reset  (fpga_reset),
        .halted      (halted),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .diag_req    (diag_req),
        .diag_we     (diag_we),
        .diag_address(diag_address),
        .diag_wdata  (diag_wdata),
        .diag_rdata  (diag_rdata),
        .diag_ack    (diag_ack),
        .ram_address (ram_address),
        .ram_data_out(ram_data_out),
        .ram_data_in (ram_data_in),
        .ram_we      (ram_we),
        .ram_cs      (ram_cs),
        .owner       (owner),
        .diag_starved(diag_starved)
    );

    always #5 fpga_clk = ~fpga_clk;

    always @(posedge fpga_clk) cyc <= cyc + 1;

    // Synchronous RAM: write on cs&we, read data one cycle after the address.
    always @(posedge fpga_clk) begin
        if (ram_cs && ram_we) mem[ram_address] <= ram_data_out;
        ram_data_in <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bus invariants sampled on the falling edge.
    logic cpu_ack_q  = 1'b0;
    logic diag_ack_q = 1'b0;
    int   we_run     = 0;
    always @(negedge fpga_clk) begin
        if (fpga_reset) begin
            we_run     <= 0;
            cpu_ack_q  <= 1'b0;
            diag_ack_q <= 1'b0;
        end else begin
            chk("we_needs_cs", 32'(ram_we & ~ram_cs), 32'd0);
            chk("owner_legal", 32'(owner == 2'b11), 32'd0);
            chk("cpu_ack_1cyc", 32'(cpu_ack & cpu_ack_q), 32'd0);
            chk("diag_ack_1cyc", 32'(diag_ack & diag_ack_q), 32'd0);
            if (ram_we) begin
                we_run <= we_run + 1;
            end else if (we_run != 0) begin
                chk("we_pulse_len", 32'(we_run), 32'(WP));
                we_run <= 0;
            end
            cpu_ack_q  <= cpu_ack;
            diag_ack_q <= diag_ack;
        end
    end

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic wait_any_ack(output int n, input bit flip_h);
        n = 0;
        do begin
            tick();
            n++;
            if (flip_h && n == 1) halted = ~halted;
        end while (!(cpu_ack || diag_ack) && n < 60);
        chk("ack_seen", 32'(cpu_ack | diag_ack), 32'd1);
    endtask

    // One arbitration round: raise the enabled requests together, then expect the winner,
    // followed by the other requester if both asked.
    task automatic do_txn(input bit h, input bit c_en, input bit d_en, input bit c_w, input bit d_w,
                          input logic [15:0] c_a, input logic [15:0] d_a,
                          input logic [7:0] c_d, input logic [7:0] d_d, input bit flip);
        int n;
        bit first_diag;
        bit sd;
        bit w;
        logic [15:0] a;
        logic [7:0] d;
        logic [7:0] other_rd;
        halted       = h;
        cpu_we       = c_w;
        cpu_address  = c_a;
        cpu_wdata    = c_d;
        diag_we      = d_w;
        diag_address = d_a;
        diag_wdata   = d_d;
        cpu_req      = c_en;
        diag_req     = d_en;
        first_diag   = d_en && (h || !c_en);
        for (int k = 0; k < 2; k++) begin
            if (k == 1 && !(c_en && d_en)) break;
            sd       = (k == 0) ? first_diag : !first_diag;
            w        = sd ? d_w : c_w;
            a        = sd ? d_a : c_a;
            d        = sd ? d_d : c_d;
            other_rd = sd ? cpu_rdata : diag_rdata;
            wait_any_ack(n, flip && (k == 0));
            chk("ack_who", 32'({cpu_ack, diag_ack}), sd ? 32'd1 : 32'd2);
            chk("ack_latency", 32'(n), 32'(((k == 0) ? 3 : 4) + (w ? WP : 0)));
            chk("gap_owner", 32'(owner), 32'd0);
            chk("gap_cs", 32'(ram_cs | ram_we), 32'd0);
            if (w) ref_mem[a] = d;
            else chk("rdata", 32'(sd ? diag_rdata : cpu_rdata), 32'(ref_mem[a]));
            chk("other_rdata_kept", 32'(sd ? cpu_rdata : diag_rdata), 32'(other_rd));
            if (sd) diag_req = 1'b0;
            else    cpu_req  = 1'b0;
        end
        tick();
    endtask

    initial begin
        int n;
        int last;
        logic prev;
        repeat (2) @(posedge fpga_clk);
        #1;
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_diag_ack", 32'(diag_ack), 32'd0);
        chk("rst_ram_cs", 32'(ram_cs), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_starved", 32'(diag_starved), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_diag_rdata", 32'(diag_rdata), 32'd0);
        chk("rst_ram_address", 32'(ram_address), 32'd0);
        fpga_reset = 1'b0;
        tick();

        // Preload the RAM through the arbiter itself.
        for (int i = 0; i < 64; i++)
            do_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'(i), 16'd0, 8'($urandom), 8'd0, 1'b0);
        do_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'd0, 8'h00, 8'd0, 1'b0);
        do_txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 16'h0010, 8'd0, 8'h3C, 1'b0);
        do_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'd0, 8'h77, 8'd0, 1'b0);

        // Reset in the middle of a diagnostics write strobe.
        halted       = 1'b1;
        diag_we      = 1'b1;
        diag_address = 16'h1234;
        diag_wdata   = 8'hA5;
        diag_req     = 1'b1;
        tick();
        chk("rst_mid_setup_owner", 32'(owner), 32'd2);
        chk("rst_mid_setup_cs", 32'(ram_cs), 32'd1);
        diag_req = 1'b0;
        tick();
        chk("rst_mid_strobe_we", 32'(ram_we), 32'd1);
        chk("rst_mid_strobe_addr", 32'(ram_address), 32'h1234);
        fpga_reset = 1'b1;
        #1;
        chk("rst_mid_we_drop", 32'(ram_we), 32'd0);
        chk("rst_mid_cs_drop", 32'(ram_cs), 32'd0);
        chk("rst_mid_owner_drop", 32'(owner), 32'd0);
        tick();
        fpga_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_mid_no_ack", 32'(diag_ack | cpu_ack), 32'd0);
            chk("rst_mid_idle_cs", 32'(ram_cs), 32'd0);
        end
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'd0, 8'd0, 8'd0, 1'b0);
        chk("rst_mid_not_written", 32'(cpu_rdata), 32'h00);

        // Simultaneous reads, both priority modes.
        do_txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0020, 8'd0, 8'd0, 1'b0);
        chk("sim_h0_cpu_rdata", 32'(cpu_rdata), 32'h3C);
        chk("sim_h0_diag_rdata", 32'(diag_rdata), 32'h77);
        do_txn(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0010, 8'd0, 8'd0, 1'b0);
        chk("sim_h1_diag_rdata", 32'(diag_rdata), 32'h3C);
        chk("sim_h1_cpu_rdata", 32'(cpu_rdata), 32'h77);

        // Write pulse shape with WRITE_PULSE=3.
        halted      = 1'b0;
        cpu_we      = 1'b1;
        cpu_address = 16'hFFFF;
        cpu_wdata   = 8'h5A;
        cpu_req     = 1'b1;
        tick();
        chk("wr_setup_cs", 32'(ram_cs), 32'd1);
        chk("wr_setup_we", 32'(ram_we), 32'd0);
        chk("wr_setup_owner", 32'(owner), 32'd1);
        cpu_req = 1'b0;
        for (int i = 0; i < WP; i++) begin
            tick();
            chk("wr_strobe_we", 32'(ram_we), 32'd1);
            chk("wr_strobe_addr", 32'(ram_address), 32'hFFFF);
            chk("wr_strobe_data", 32'(ram_data_out), 32'h5A);
        end
        tick();
        chk("wr_hold_we", 32'(ram_we), 32'd0);
        chk("wr_hold_cs", 32'(ram_cs), 32'd1);
        chk("wr_hold_ack", 32'(cpu_ack), 32'd0);
        tick();
        chk("wr_ack_at_6", 32'(cpu_ack), 32'd1);
        ref_mem[16'hFFFF] = 8'h5A;
        tick();
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'd0, 8'd0, 8'd0, 1'b0);
        chk("wr_readback", 32'(cpu_rdata), 32'h5A);

        // Starvation under a continuously requesting CPU.
        halted       = 1'b0;
        cpu_we       = 1'b0;
        cpu_address  = 16'd5;
        diag_we      = 1'b0;
        diag_address = 16'd7;
        cpu_req      = 1'b1;
        diag_req     = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("starved_level", 32'(diag_starved), 32'(k >= SL));
        end
        cpu_req = 1'b0;
        prev    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            prev = diag_starved;
            tick();
            if (owner == 2'b10) break;
        end
        chk("starve_diag_granted", 32'(owner), 32'd2);
        chk("starve_pre_grant", 32'(prev), 32'd1);
        chk("starve_clear_on_grant", 32'(diag_starved), 32'd0);
        wait_any_ack(n, 1'b0);
        chk("starve_diag_ack", 32'(diag_ack), 32'd1);
        chk("starve_diag_rdata", 32'(diag_rdata), 32'(ref_mem[7]));
        diag_req = 1'b0;
        tick();

        // Back-to-back diagnostics reads while halted.
        halted  = 1'b1;
        diag_we = 1'b0;
        last    = 0;
        for (int i = 0; i < 4; i++) begin
            diag_address = 16'(i);
            diag_req     = 1'b1;
            wait_any_ack(n, 1'b0);
            chk("b2b_who", 32'(diag_ack), 32'd1);
            if (i == 0) chk("b2b_first_latency", 32'(n), 32'd3);
            else        chk("b2b_spacing", 32'(cyc - last), 32'd4);
            last = cyc;
            chk("b2b_rdata", 32'(diag_rdata), 32'(ref_mem[i]));
            chk("b2b_gap_owner", 32'(owner), 32'd0);
            diag_req = 1'b0;
            tick();
        end

        // Randomized arbitration rounds.
        for (int i = 0; i < 60; i++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(1, 3));
            do_txn(1'($urandom), sel[0], sel[1], 1'($urandom), 1'($urandom),
                   16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)),
                   8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit, expected test completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single ROMulator RAM port between two requesters: the CPU bus front end and the SPI diagnostics engine.
- Sequences each access (address setup, write strobe, read capture) and returns a one-cycle ack to the winning requester.
- CPU has priority while running; diagnostics has priority while the CPU is halted.
- A starvation counter flags diagnostics requests that wait too long.

Parameters:
ADDR_WIDTH, 16, RAM address width
DATA_WIDTH, 8, RAM data width
WRITE_PULSE, 1, cycles ram_we is held high per write (1..15)
STARVE_LIMIT, 255, wait cycles before diag_starved asserts (1..255)

Ports:
fpga_clk  in  1  system clock; all logic on rising edge
fpga_reset  in  1  asynchronous, active-high reset
halted  in  1  CPU halted (from diagnostics halt output)
cpu_req  in  1  CPU access request; level, held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req high
cpu_address  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_rdata  out  DATA_WIDTH  CPU read data; valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
diag_req, diag_we, diag_address, diag_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  same semantics for diagnostics
diag_rdata  out  DATA_WIDTH  diagnostics read data; valid with diag_ack
diag_ack  out  1  one-cycle completion pulse
ram_address  out  ADDR_WIDTH  RAM address
ram_data_out  out  DATA_WIDTH  RAM write data
ram_data_in  in  DATA_WIDTH  RAM read data; valid one cycle after address/cs
ram_we  out  1  RAM write enable
ram_cs  out  1  RAM chip select
owner  out  2  00 none, 01 CPU, 10 diag
diag_starved  out  1  diagnostics wait has reached STARVE_LIMIT

Behaviour:
- Reset (async, any state): all outputs 0; FSM to IDLE; starvation counter 0.
- An in-flight transaction is abandoned with no ack; nothing is written after reset asserts.
- FSM states: IDLE, SETUP, STROBE, HOLD, CAPTURE, GAP.
- IDLE, arbitration:
  - halted=0: cpu_req wins; diag_req is served only if cpu_req=0.
  - halted=1: diag_req wins; cpu_req is served only if diag_req=0.
  - On a grant, latch requester, we, address and wdata into internal registers, set owner, go to SETUP.
  - With no request: owner=00, ram_cs=0.
- SETUP: ram_cs=1; ram_address and ram_data_out come from the latched values. Write -> STROBE; read -> CAPTURE.
- STROBE: ram_we=1 for exactly WRITE_PULSE cycles (internal counter), then HOLD.
- HOLD: ram_we=0; address, data and cs held; ack pulses to owner; then GAP.
- CAPTURE: latch ram_data_in into the owner's rdata; ack pulses this cycle; then GAP.
- The non-owner's rdata is never modified.
- GAP: ram_cs=0, owner=00; both requests ignored for one cycle; then IDLE.
- Requesters must drop req by GAP; a req still high in IDLE is treated as a new transaction.
- Latency from req sampled in IDLE to ack:
  - read: 3 cycles (IDLE, SETUP, CAPTURE)
  - write: 3+WRITE_PULSE cycles
  - minimum spacing between acks: read 4 cycles, write 4+WRITE_PULSE cycles
- Request changes after the grant have no effect on the current transaction.
- A halted change mid-transaction does not preempt it; it affects only the next IDLE arbitration.
- Starvation counter (8-bit):
  - increments each cycle diag_req=1 and the FSM is not serving diag
  - saturates at STARVE_LIMIT; diag_starved=1 while count==STARVE_LIMIT
  - clears to 0 when diag is granted or diag_req=0
- ram_we is never 1 unless ram_cs=1; ram_we and ram_cs are never 1 in IDLE or GAP.

Test Plan:
- Reset mid-write: diag write 0x1234<=0xA5, fpga_reset pulsed during STROBE -> ram_we, ram_cs, owner drop to 0 immediately; no diag_ack; FSM in IDLE after release.
- Simultaneous requests, halted=0: cpu read 0x0010 (RAM=0x3C), diag read 0x0020 -> CPU served first; cpu_rdata=0x3C, cpu_ack 3 cycles after sample; diag served next, diag_ack 4 cycles after cpu_ack.
- Simultaneous requests, halted=1: same stimulus -> diag served first; CPU second.
- Write timing, WRITE_PULSE=3: cpu write 0xFFFF<=0x5A -> ram_we high exactly 3 cycles with ram_address=0xFFFF, ram_data_out=0x5A; cpu_ack 6 cycles after sample; readback gives 0x5A.
- Starvation, STARVE_LIMIT=10: halted=0, cpu_req held continuously, diag_req=1 -> diag_starved rises 10 cycles after diag_req; clears the cycle diag is granted once cpu_req drops.
- Back-to-back reads 0x0000..0x0003 by diag, halted=1, req re-raised in IDLE after each ack -> acks 4 cycles apart; rdata matches RAM; owner=00 during every GAP.
